// File: rtl/nco_multichannel.sv
`default_nettype none
// ============================================================================
// Module      : nco_multichannel
// Description : Time-multiplexed multi-channel numerically controlled
//               oscillator. CHANNELS phase accumulators share one waveform
//               datapath. Per-channel configuration is written into shadow
//               registers and copied to the active set at a sample tick
//               after a commit request. On every tick all channels are
//               scanned in order and emitted as a tagged sample stream.
// Ports       : clk, rst_n            - clock, async active-low reset
//               cfg_we/ch/addr/data   - shadow register write port
//               cfg_commit            - request shadow->active copy
//               cfg_pending           - commit requested, not yet applied
//               out_valid/ch/last/data- tagged sample stream
// Revision    : 1.0 - initial release
// ============================================================================
module nco_multichannel #(
    parameter int CHANNELS    = 4,
    parameter int BIT_DEPTH   = 12,
    parameter int ACC_WIDTH   = 32,
    parameter int CLK_FREQ    = 48000000,
    parameter int SAMPLE_RATE = 48000,
    localparam int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [CW-1:0]        cfg_ch,
    input  logic [2:0]           cfg_addr,
    input  logic [ACC_WIDTH-1:0] cfg_data,
    input  logic                 cfg_commit,
    output logic                 cfg_pending,
    output logic                 out_valid,
    output logic [CW-1:0]        out_ch,
    output logic                 out_last,
    output logic [BIT_DEPTH-1:0] out_data
);

    localparam int DIV  = CLK_FREQ / SAMPLE_RATE;
    localparam int CNTW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW   = BIT_DEPTH + 3;

    localparam logic [CNTW-1:0]      c_DIV_LAST = CNTW'(DIV - 1);
    localparam logic [CW-1:0]        c_CH_LAST  = CW'(CHANNELS - 1);
    localparam logic [BIT_DEPTH-1:0] c_MAX      = '1;
    localparam logic [BIT_DEPTH-1:0] c_HALF     = {1'b1, {(BIT_DEPTH-1){1'b0}}};

    localparam logic [1:0] c_WAVE_SINE = 2'd0;
    localparam logic [1:0] c_WAVE_TRI  = 2'd1;
    localparam logic [1:0] c_WAVE_SAW  = 2'd2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    generate
        if (DIV < CHANNELS + 2) begin : g_div_check
            $error("nco_multichannel: CLK_FREQ/SAMPLE_RATE must be >= CHANNELS+2");
        end
    endgenerate

    // Shadow (written by cfg port) and active (used by datapath) sets
    logic [ACC_WIDTH-1:0] r_sh_inc  [CHANNELS];
    logic [ACC_WIDTH-1:0] r_sh_off  [CHANNELS];
    logic [1:0]           r_sh_wave [CHANNELS];
    logic [BIT_DEPTH-1:0] r_sh_duty [CHANNELS];
    logic                 r_sh_en   [CHANNELS];
    logic                 r_sh_clr  [CHANNELS];

    logic [ACC_WIDTH-1:0] r_inc  [CHANNELS];
    logic [ACC_WIDTH-1:0] r_off  [CHANNELS];
    logic [1:0]           r_wave [CHANNELS];
    logic [BIT_DEPTH-1:0] r_duty [CHANNELS];
    logic                 r_en   [CHANNELS];
    logic [ACC_WIDTH-1:0] r_acc  [CHANNELS];

    logic [CNTW-1:0] r_cnt;
    logic            r_pending;
    logic [0:0]      r_state;
    logic [CW-1:0]   r_k;

    logic w_tick;
    logic w_commit;
    logic w_wr_ok;

    assign w_tick   = (r_cnt == '0);
    // A commit strobe coinciding with the tick is applied at that tick
    assign w_commit = w_tick && (r_pending || cfg_commit);
    assign w_wr_ok  = cfg_we && (32'(cfg_ch) < CHANNELS);

    assign cfg_pending = r_pending;

    // Sample-rate divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == c_DIV_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (w_commit) begin
            r_pending <= 1'b0;
        end else if (cfg_commit) begin
            r_pending <= 1'b1;
        end
    end

    // Shadow/active registers. The copy reads the shadow value from before
    // this edge, so a write in the tick cycle only reaches the shadow set.
    // The write is placed after the clear self-reset so a fresh control
    // write in the commit cycle is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_sh_inc[i]  <= '0;
                r_sh_off[i]  <= '0;
                r_sh_wave[i] <= c_WAVE_SINE;
                r_sh_duty[i] <= '0;
                r_sh_en[i]   <= 1'b0;
                r_sh_clr[i]  <= 1'b0;
                r_inc[i]     <= '0;
                r_off[i]     <= '0;
                r_wave[i]    <= c_WAVE_SINE;
                r_duty[i]    <= '0;
                r_en[i]      <= 1'b0;
            end
        end else begin
            if (w_commit) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    r_inc[i]    <= r_sh_inc[i];
                    r_off[i]    <= r_sh_off[i];
                    r_wave[i]   <= r_sh_wave[i];
                    r_duty[i]   <= r_sh_duty[i];
                    r_en[i]     <= r_sh_en[i];
                    r_sh_clr[i] <= 1'b0;
                end
            end
            if (w_wr_ok) begin
                case (cfg_addr)
                    3'd0: r_sh_inc[cfg_ch]  <= cfg_data;
                    3'd1: r_sh_off[cfg_ch]  <= cfg_data;
                    3'd2: r_sh_wave[cfg_ch] <= cfg_data[1:0];
                    3'd3: r_sh_duty[cfg_ch] <= cfg_data[BIT_DEPTH-1:0];
                    3'd4: begin
                        r_sh_en[cfg_ch]  <= cfg_data[0];
                        r_sh_clr[cfg_ch] <= cfg_data[1];
                    end
                    default: ;
                endcase
            end
        end
    end

    // Accumulators: cleared at a commit edge (which is always in IDLE since
    // the divider leaves room for the whole scan), advanced during the scan
    // after their phase has been sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_commit && r_sh_clr[i]) begin
                    r_acc[i] <= '0;
                end
            end
            if (r_state == S_SCAN && r_en[r_k]) begin
                r_acc[r_k] <= r_acc[r_k] + r_inc[r_k];
            end
        end
    end

    // Scan controller
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state <= S_SCAN;
                        r_k     <= '0;
                    end
                end
                default: begin
                    if (r_k == c_CH_LAST) begin
                        r_state <= S_IDLE;
                        r_k     <= '0;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
            endcase
        end
    end

    // Waveform datapath for the channel currently being scanned
    logic [BIT_DEPTH-1:0] w_phase;
    logic [BIT_DEPTH-2:0] w_h;
    logic [2*BIT_DEPTH-1:0] w_hsq;
    logic [SW-1:0]        w_q;
    logic [SW-1:0]        w_up;
    logic [SW-1:0]        w_dn;
    logic [BIT_DEPTH-1:0] w_sine;
    logic [BIT_DEPTH-1:0] w_sample;

    assign w_phase = BIT_DEPTH'((r_acc[r_k] + r_off[r_k]) >> (ACC_WIDTH - BIT_DEPTH));
    assign w_h     = w_phase[BIT_DEPTH-2:0];
    assign w_hsq   = (2*BIT_DEPTH)'(w_h) * (2*BIT_DEPTH)'(w_h);
    // (8*h*h) >> BIT_DEPTH written as h*h >> (BIT_DEPTH-3)
    assign w_q     = SW'(w_hsq >> (BIT_DEPTH - 3));
    assign w_up    = SW'(c_HALF) + (SW'(w_h) << 2) - w_q;
    assign w_dn    = SW'(c_HALF) - (SW'(w_h) << 2) + w_q;
    // Lower half-cycle never exceeds MAX; the clamp is shared for symmetry
    assign w_sine  = w_phase[BIT_DEPTH-1]
                   ? ((w_dn > SW'(c_MAX)) ? c_MAX : w_dn[BIT_DEPTH-1:0])
                   : ((w_up > SW'(c_MAX)) ? c_MAX : w_up[BIT_DEPTH-1:0]);

    always_comb begin
        w_sample = c_HALF;
        if (r_en[r_k]) begin
            case (r_wave[r_k])
                c_WAVE_SINE: w_sample = w_sine;
                c_WAVE_TRI:  w_sample = w_phase[BIT_DEPTH-1] ? ((c_MAX - w_phase) << 1)
                                                             : (w_phase << 1);
                c_WAVE_SAW:  w_sample = w_phase;
                default:     w_sample = (w_phase < r_duty[r_k]) ? c_MAX : '0;
            endcase
        end
    end

    // Output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (r_state == S_SCAN) begin
            out_valid <= 1'b1;
            out_ch    <= r_k;
            out_last  <= (r_k == c_CH_LAST);
            out_data  <= w_sample;
        end else begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nco_multichannel.sv
`default_nettype none
// ============================================================================
// Module      : tb_nco_multichannel
// Description : Self-checking bench for nco_multichannel (4 channels, 8-bit
//               samples, 32-bit accumulators, 8 clocks per sample period).
//               A sample-period level reference model predicts each tagged
//               sample and the commit-pending flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_multichannel;

    localparam int CH   = 4;
    localparam int BD   = 8;
    localparam int AW   = 32;
    localparam int DIV  = 8;
    localparam int MAXV = (1 << BD) - 1;
    localparam int HALFV = 1 << (BD - 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_we;
    logic [1:0]    cfg_ch;
    logic [2:0]    cfg_addr;
    logic [AW-1:0] cfg_data;
    logic          cfg_commit;
    logic          cfg_pending;
    logic          out_valid;
    logic [1:0]    out_ch;
    logic          out_last;
    logic [BD-1:0] out_data;

    nco_multichannel #(
        .CHANNELS   (CH),
        .BIT_DEPTH  (BD),
        .ACC_WIDTH  (AW),
        .CLK_FREQ   (DIV),
        .SAMPLE_RATE(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .cfg_pending(cfg_pending),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_last   (out_last),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // ---------------- reference model ----------------
    logic [AW-1:0] s_inc [CH], s_off [CH], a_inc [CH], a_off [CH], acc [CH];
    logic [1:0]    s_wave[CH], a_wave[CH];
    logic [BD-1:0] s_duty[CH], a_duty[CH];
    bit            s_en [CH], a_en [CH], s_clr[CH];
    bit            m_pend;
    int            e;

    typedef struct {
        int due;
        int ch;
        int data;
    } exp_t;
    exp_t expq[$];

    function automatic int ref_sample(bit en, logic [1:0] w, int ph, int duty);
        int h, q, y;
        if (!en) return HALFV;
        case (w)
            2'd0: begin
                h = ph % HALFV;
                q = (8 * h * h) >> BD;
                if (ph < HALFV) begin
                    y = HALFV + 4 * h - q;
                    if (y > MAXV) y = MAXV;
                end else begin
                    y = HALFV - 4 * h + q;
                end
            end
            2'd1:    y = (ph < HALFV) ? 2 * ph : 2 * (MAXV - ph);
            2'd2:    y = ph;
            default: y = (ph < duty) ? MAXV : 0;
        endcase
        return y;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            s_inc[i] = '0; s_off[i] = '0; a_inc[i] = '0; a_off[i] = '0; acc[i] = '0;
            s_wave[i] = 2'd0; a_wave[i] = 2'd0; s_duty[i] = '0; a_duty[i] = '0;
            s_en[i] = 1'b0; a_en[i] = 1'b0; s_clr[i] = 1'b0;
        end
        m_pend = 1'b0;
        e = 0;
        expq.delete();
    endtask

    // One clock edge of the specified behaviour, at sample-period granularity
    task automatic model_edge();
        logic [AW-1:0] sum;
        int ph;
        if (e % DIV == 0) begin
            if (m_pend || cfg_commit) begin
                for (int i = 0; i < CH; i++) begin
                    a_inc[i] = s_inc[i]; a_off[i] = s_off[i]; a_wave[i] = s_wave[i];
                    a_duty[i] = s_duty[i]; a_en[i] = s_en[i];
                    if (s_clr[i]) acc[i] = '0;
                    s_clr[i] = 1'b0;
                end
                m_pend = 1'b0;
            end
            for (int k = 0; k < CH; k++) begin
                sum = acc[k] + a_off[k];
                ph = int'(sum >> (AW - BD));
                expq.push_back('{due: e + 1 + k, ch: k,
                                 data: ref_sample(a_en[k], a_wave[k], ph, int'(a_duty[k]))});
                if (a_en[k]) acc[k] = acc[k] + a_inc[k];
            end
        end else if (cfg_commit) begin
            m_pend = 1'b1;
        end
        if (cfg_we && int'(cfg_ch) < CH) begin
            case (cfg_addr)
                3'd0: s_inc[cfg_ch]  = cfg_data;
                3'd1: s_off[cfg_ch]  = cfg_data;
                3'd2: s_wave[cfg_ch] = cfg_data[1:0];
                3'd3: s_duty[cfg_ch] = cfg_data[BD-1:0];
                3'd4: begin
                    s_en[cfg_ch]  = cfg_data[0];
                    s_clr[cfg_ch] = cfg_data[1];
                end
                default: ;
            endcase
        end
        e++;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, expv, e);
        end
    endtask

    task automatic check_edge(input int cur);
        exp_t x;
        chk("cfg_pending", 64'(cfg_pending), 64'(m_pend));
        if (expq.size() > 0 && expq[0].due == cur) begin
            x = expq.pop_front();
            chk("out_valid", 64'(out_valid), 64'd1);
            chk("out_ch",    64'(out_ch),    64'(x.ch));
            chk("out_last",  64'(out_last),  64'(x.ch == CH - 1));
            chk($sformatf("out_data_ch%0d", x.ch), 64'(out_data), 64'(x.data));
        end else begin
            chk("out_valid_idle", 64'(out_valid), 64'd0);
        end
    endtask

    task automatic step();
        int cur;
        @(posedge clk);
        cur = e;
        model_edge();
        #1;
        check_edge(cur);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input int ch, input int addr, input logic [AW-1:0] data);
        cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_addr = 3'(addr); cfg_data = data;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic commit();
        cfg_commit = 1'b1;
        step();
        cfg_commit = 1'b0;
    endtask

    // Advance until the next edge to be applied has the given period offset
    task automatic goto_phase(input int p);
        while (e % DIV != p) step();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"},   64'(out_valid),   64'd0);
        chk({tag, "_data"},    64'(out_data),    64'd0);
        chk({tag, "_ch"},      64'(out_ch),      64'd0);
        chk({tag, "_last"},    64'(out_last),    64'd0);
        chk({tag, "_pending"}, 64'(cfg_pending), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0;
        cfg_data = '0; cfg_commit = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Unconfigured: all channels mid-scale
        run(2 * DIV);

        // ch0 sawtooth, ch1 square, ch2 sine, ch3 triangle
        wr(0, 0, 32'h0100_0000); wr(0, 2, 32'd2); wr(0, 4, 32'd1);
        wr(1, 0, 32'h4000_0000); wr(1, 2, 32'd3); wr(1, 3, 32'h80); wr(1, 4, 32'd1);
        wr(2, 0, 32'h4000_0000); wr(2, 2, 32'd0); wr(2, 4, 32'd1);
        wr(3, 0, 32'h4000_0000); wr(3, 2, 32'd1); wr(3, 4, 32'd1);
        commit();
        run(260 * DIV);

        // Square with zero duty
        wr(1, 3, 32'd0);
        commit();
        run(4 * DIV);

        // ch0 offset half-scale, no increment, accumulator cleared at commit
        wr(0, 1, 32'h8000_0000); wr(0, 0, 32'd0); wr(0, 4, 32'd3);
        commit();
        run(3 * DIV);
        // Shadow-only change must not show before commit
        wr(0, 0, 32'h0300_0000);
        run(2 * DIV);
        goto_phase(3);
        commit();
        run(2 * DIV);

        // Commit and a shadow write both in the tick cycle
        goto_phase(0);
        cfg_commit = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_addr = 3'd2; cfg_data = 32'd1;
        step();
        cfg_commit = 1'b0; cfg_we = 1'b0;
        run(2 * DIV);
        commit();
        run(2 * DIV);

        // Randomized configuration traffic
        for (int it = 0; it < 60; it++) begin
            wr(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 7)), $urandom);
            if ($urandom_range(0, 2) == 0) commit();
            run(int'($urandom_range(0, 12)));
        end
        commit();
        run(6 * DIV);

        // Reset in the middle of a scan with a commit outstanding
        goto_phase(2);
        commit();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run(3 * DIV);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nco_multichannel.md
Name: nco_multichannel

Overview:
- Time-multiplexed, multi-channel numerically controlled oscillator; next generation of the single-channel NCO.
- CHANNELS independent oscillators share one waveform datapath.
- Each channel has its own phase increment, phase offset, waveform, duty cycle and enable.
- Configuration is double-buffered and applied atomically at a sample boundary; one sample per channel is emitted as a tagged stream per sample period.

Parameters:
CHANNELS, 4, number of oscillators (1..16)
BIT_DEPTH, 12, output sample width and phase word width (4..16)
ACC_WIDTH, 32, phase accumulator width (BIT_DEPTH+4..48)
CLK_FREQ, 48000000, clk frequency in Hz
SAMPLE_RATE, 48000, sample rate in Hz; DIV = CLK_FREQ/SAMPLE_RATE, elaboration error if DIV < CHANNELS+2

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
cfg_we  input  1  shadow register write strobe
cfg_ch  input  $clog2(CHANNELS) (min 1)  target channel
cfg_addr  input  3  0 phase_inc, 1 phase_offset, 2 wave, 3 duty, 4 control
cfg_data  input  ACC_WIDTH  write data, LSB-aligned
cfg_commit  input  1  request shadow-to-active copy at next sample tick
cfg_pending  output  1  commit requested but not yet applied
out_valid  output  1  out_data/out_ch valid this cycle
out_ch  output  $clog2(CHANNELS) (min 1)  channel of current sample
out_last  output  1  asserted with the sample of channel CHANNELS-1
out_data  output  BIT_DEPTH  unsigned sample

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - All accumulators, active and shadow registers 0; wave=SINE, duty=0, enable=0.
  - Tick counter 0.
- Reset mid-scan aborts the scan; no partial stream is resumed.
- Tick: counter runs 0..DIV-1; tick is asserted when counter==0. If DIV==1, tick every cycle (only legal if CHANNELS+2<=1, so effectively disallowed).
- Commit:
  - cfg_commit sets pending.
  - On the tick cycle, if pending, all shadow registers are copied to active and pending clears.
  - A cfg_we in the same cycle as the tick lands in shadow, not active.
  - cfg_commit and a tick in the same cycle: commit applies at that tick.
- Control word (addr 4):
  - bit0 enable.
  - bit1 clear: on commit, accumulator := 0. Clear is self-clearing in shadow after commit.
- Writes:
  - wave uses cfg_data[1:0]; duty uses cfg_data[BIT_DEPTH-1:0]. Upper bits are ignored.
  - cfg_ch >= CHANNELS: write ignored.
- States: IDLE, SCAN.
  - IDLE -> SCAN on tick (after commit); k := 0.
  - In SCAN, one channel per cycle; k increments; SCAN -> IDLE after k==CHANNELS-1.
- Pipeline per channel k:
  - Stage 1 (scan cycle k): phase = (acc[k] + offset[k]) top BIT_DEPTH bits, modulo 2^ACC_WIDTH. Then acc[k] := acc[k] + inc[k] (wraps) if enabled, else held.
  - Stage 2 registers out_data. out_valid/out_ch/out_last are valid at tick_cycle + k + 2.
  - Samples reflect the phase before that tick's increment.
- Waveforms (MAX = 2^BIT_DEPTH-1, HALF = 2^(BIT_DEPTH-1)):
  - Disabled channel: out_data = HALF, still emitted.
  - 0 SINE, parabolic: h = phase[BIT_DEPTH-2:0], q = (8*h*h) >> BIT_DEPTH.
    - MSB 0: y = HALF + 4h - q, saturate to MAX.
    - MSB 1: y = HALF - 4h + q (never negative).
    - Intermediate width BIT_DEPTH+3 minimum.
  - 1 TRIANGLE: phase < HALF ? 2*phase : 2*(MAX-phase).
  - 2 SAWTOOTH: phase.
  - 3 SQUARE: phase < duty ? MAX : 0. duty=0 gives constant 0.
- out_valid is exactly CHANNELS consecutive pulses per tick; channels are never skipped or reordered.

Test Plan:
- BIT_DEPTH=8, ACC_WIDTH=32, CHANNELS=4, DIV=8; ch0 sawtooth, inc=0x01000000, enable, commit -> ch0 samples on successive ticks 0,1,2,...,255,0 (wrap); other channels 128.
- ch1 square, duty=0x80, inc=0x40000000 -> ch1 samples 255,255,0,0 repeating; duty=0 -> constant 0.
- ch2 sine, inc=0x40000000 -> 128,255,128,0 repeating; ch3 triangle same inc -> 0,128,254,126.
- ch0 offset=0x80000000 with sawtooth inc=0 -> constant 128; write inc without commit -> output unchanged; commit -> change seen starting the next tick, cfg_pending high exactly until that tick.
- Timing check -> out_valid pulses at tick+2..tick+5, out_ch 0,1,2,3, out_last only on ch3; commit with clear bit -> ch accumulator restarts at 0 at that tick.
- Assert rst_n low during SCAN -> out_valid, out_data, cfg_pending drop to 0 immediately (async); after release, all channels emit 128 until configured.
